// File: rtl/tone_envelope_pkg.sv
// tone_envelope_pkg: shared types and helpers for the tone envelope stage.
//   env_state_t  - envelope state (IDLE, HOLD, DECAY), 2 bits
//   env_max()    - full-scale envelope value for a given envelope width
//   amp_shift()  - left shift placing the envelope just under the sample sign bit
package tone_envelope_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } env_state_t;

  function automatic int unsigned env_max(input int unsigned env_width);
    return (32'd1 << env_width) - 32'd1;
  endfunction

  function automatic int unsigned amp_shift(input int unsigned sample_width,
                                            input int unsigned env_width);
    return sample_width - 32'd1 - env_width;
  endfunction

endpackage

// File: rtl/env_tick_gen.sv
// env_tick_gen: envelope prescaler. Counts clk cycles while run is high and
// emits a one-cycle tick every DIV cycles.
//   clk, reset - clock, synchronous active-high reset
//   run        - count enable (envelope busy)
//   clear      - restart the count from 0 (trigger edge)
//   tick       - combinational, high in the cycle the count sits at DIV-1
module env_tick_gen #(
  parameter int unsigned DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = run & (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tone_envelope.sv
// tone_envelope: gates a 555 square wave with a triggered hold-then-decay
// envelope and produces one signed/unsigned audio sample per clk.
//   clk, reset  - clock, synchronous active-high reset
//   tone_in     - square wave input (same clock domain)
//   trigger     - level input; each rising edge (re)starts the envelope
//   sample_out  - registered audio sample
//   active      - high while the envelope is in HOLD or DECAY
// Build option: define TONE_ENVELOPE_SIGNED_EN for bipolar (+amp/-amp) output;
// otherwise the output is unipolar (amp/0).
module tone_envelope
  import tone_envelope_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ENV_WIDTH    = 8,
  parameter int unsigned DECAY_DIV    = 1000,
  parameter int unsigned DECAY_SHIFT  = 4,
  parameter int unsigned HOLD_TICKS   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tone_in,
  input  logic                    trigger,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic                    active
);

  localparam int unsigned AMP_SHIFT = amp_shift(SAMPLE_WIDTH, ENV_WIDTH);
  localparam logic [ENV_WIDTH-1:0] ENV_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));
  // hold_cnt only ever needs to reach HOLD_TICKS-1.
  localparam int unsigned HC_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'((HOLD_TICKS > 0) ? HOLD_TICKS - 1 : 0);

  env_state_t             state, state_n;
  logic [ENV_WIDTH-1:0]   env, env_n;
  logic [HC_W-1:0]        hold_cnt, hold_n;
  logic                   trig_d;
  logic                   trig_edge;
  logic                   tick;
  logic [ENV_WIDTH-1:0]   dec;
  logic [SAMPLE_WIDTH-1:0] amp;
  logic [SAMPLE_WIDTH-1:0] sample_n;

  assign trig_edge = trigger & ~trig_d;

  env_tick_gen #(
    .DIV(DECAY_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (state != IDLE),
    .clear(trig_edge),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      env        <= '0;
      hold_cnt   <= '0;
      trig_d     <= 1'b0;
      active     <= 1'b0;
      sample_out <= '0;
    end else begin
      state      <= state_n;
      env        <= env_n;
      hold_cnt   <= hold_n;
      trig_d     <= trigger;
      active     <= (state_n != IDLE);
      sample_out <= sample_n;
    end
  end

  always_comb begin
    state_n = state;
    env_n   = env;
    hold_n  = hold_cnt;

    dec = env >> DECAY_SHIFT;
    if (dec == '0) begin
      dec = ENV_WIDTH'(1);
    end

    // A trigger edge outranks any tick landing in the same cycle.
    if (trig_edge) begin
      env_n   = ENV_MAX;
      hold_n  = '0;
      state_n = (HOLD_TICKS == 0) ? DECAY : HOLD;
    end else if (tick) begin
      case (state)
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state_n = DECAY;
          end else begin
            hold_n = hold_cnt + HC_W'(1);
          end
        end
        DECAY: begin
          if (env > dec) begin
            env_n = env - dec;
          end else begin
            env_n   = '0;
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end

    // Output uses the pre-update env, giving the one-cycle tone latency.
    amp = SAMPLE_WIDTH'(env) << AMP_SHIFT;
`ifdef TONE_ENVELOPE_SIGNED_EN
    sample_n = tone_in ? amp : -amp;
`else
    sample_n = tone_in ? amp : '0;
`endif
  end

endmodule

// File: tb/tb_tone_envelope.sv
// tb_tone_envelope: randomized scoreboard bench for tone_envelope.
// Expected outputs come from a time-based envelope model (ticks elapsed since
// the last trigger edge, mapped through a precomputed decay table).
module tb_tone_envelope;

  localparam int SW    = 16;
  localparam int EW    = 8;
  localparam int DIV   = 4;
  localparam int SHIFT = 2;
  localparam int HOLD  = 2;
  localparam int EMAX  = (1 << EW) - 1;

  typedef struct {
    logic [SW-1:0] s;
    logic          a;
    int            n;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tone_in = 1'b0;
  logic          trigger = 1'b0;
  logic [SW-1:0] sample_out;
  logic          active;

  int checks = 0;
  int failures = 0;

  exp_t sb[$];
  int   tab[$];

  int   edge_n = 0;
  int   trig_start = -1;
  logic prev_trig = 1'b0;
  int   env_prev = 0;

  always #5 clk = ~clk;

  tone_envelope #(
    .SAMPLE_WIDTH(SW),
    .ENV_WIDTH   (EW),
    .DECAY_DIV   (DIV),
    .DECAY_SHIFT (SHIFT),
    .HOLD_TICKS  (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tone_in   (tone_in),
    .trigger   (trigger),
    .sample_out(sample_out),
    .active    (active)
  );

  function automatic int env_at(input int k);
    int ticks;
    int idx;
    if (trig_start < 0) return 0;
    ticks = (k - trig_start) / DIV;
    if (ticks <= HOLD) return EMAX;
    idx = ticks - HOLD;
    if (idx < tab.size()) return tab[idx];
    return 0;
  endfunction

  function automatic logic [SW-1:0] amp_of(input int env, input logic tn);
    int a;
    int v;
    a = env * (1 << (SW - 1 - EW));
`ifdef TONE_ENVELOPE_SIGNED_EN
    v = tn ? a : -a;
`else
    v = tn ? a : 0;
`endif
    return SW'(v);
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show after the
  // upcoming clock edge.
  task automatic step(input logic r, input logic t, input logic tn);
    exp_t e;
    int   env_cur;
    @(posedge clk);
    #2;
    reset   = r;
    trigger = t;
    tone_in = tn;
    edge_n++;
    if (r) begin
      trig_start = -1;
      prev_trig  = 1'b0;
      env_cur    = 0;
      e.s        = '0;
      e.a        = 1'b0;
    end else begin
      if (t && !prev_trig) trig_start = edge_n;
      prev_trig = t;
      e.s       = amp_of(env_prev, tn);
      env_cur   = env_at(edge_n);
      e.a       = (env_cur != 0);
    end
    e.n = edge_n;
    env_prev = env_cur;
    sb.push_back(e);
  endtask

  // Monitor: one output per clk, compared against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (sample_out !== e.s) begin
          failures++;
          $display("FAIL sample_out edge=%0d got=%0d expected=%0d", e.n,
                   $signed(sample_out), $signed(e.s));
        end
        checks++;
        if (active !== e.a) begin
          failures++;
          $display("FAIL active edge=%0d got=%0b expected=%0b", e.n, active, e.a);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    int d;
    logic t;
    logic tn;
    logic r;

    tab.push_back(EMAX);
    v = EMAX;
    while (v > 0) begin
      d = v >> SHIFT;
      if (d < 1) d = 1;
      v = (v > d) ? v - d : 0;
      tab.push_back(v);
    end

    // Trigger held high through reset, then tone toggling with no new edge.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i[0]);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // Release and re-raise: full attack, hold and decay to idle.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // Retrigger at env=81 (fourth decay tick lands at E0+24).
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'($urandom_range(0, 1)));

    // Reset in the middle of an envelope.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));

    // Random traffic: occasional trigger toggles and rare resets.
    t  = 1'b0;
    tn = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) t = ~t;
      if ($urandom_range(0, 2) == 0) tn = ~tn;
      r = ($urandom_range(0, 599) == 0);
      step(r, t, tn);
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
